// File: rtl/keyword_matcher.sv
// Keyword-spotting engine: collects a character word, then scans a writable
// keyword table one entry per cycle and reports the lowest matching index.
module keyword_matcher #(
    parameter int DW       = 8,
    parameter int KEY_LEN  = 8,
    parameter int NUM_KEYS = 16,
    parameter int AW       = $clog2(NUM_KEYS),
    parameter int LW       = $clog2(KEY_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         datain,
    input  logic                  in_last,
    input  logic                  key_we,
    input  logic [AW-1:0]         key_waddr,
    input  logic [KEY_LEN*DW-1:0] key_wdata,
    input  logic [LW-1:0]         key_wlen,
    output logic [AW-1:0]         add,
    output logic                  busy,
    output logic                  match_valid,
    output logic                  match_hit,
    output logic [AW-1:0]         match_idx,
    output logic [15:0]           hit_count,
    output logic [1:0]            dbg_state
);

    // Handshake: a character transfers on a rising edge where in_valid and
    // in_ready are both high; in_ready is high only in COLLECT.
    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_SCAN    = 2'd1,
        S_REPORT  = 2'd2
    } state_t;

    state_t                r_state;
    logic [LW-1:0]         r_count;
    logic                  r_overflow;
    logic [DW-1:0]         r_buf [KEY_LEN];
    logic [AW-1:0]         r_add;
    logic                  r_match_valid;
    logic                  r_match_hit;
    logic [AW-1:0]         r_match_idx;
    logic [15:0]           r_hit_count;

    logic [KEY_LEN*DW-1:0] r_key_data [NUM_KEYS];
    logic [LW-1:0]         r_key_len  [NUM_KEYS];
    logic [NUM_KEYS-1:0]   r_key_valid;

    logic                  w_busy;
    logic                  w_accept;
    logic                  w_key_wr;
    logic                  w_chars_eq;
    logic                  w_match;
    logic [KEY_LEN*DW-1:0] w_entry_data;

    assign w_busy    = (r_state != S_COLLECT);
    assign w_accept  = in_valid && (r_state == S_COLLECT);
    assign w_key_wr  = key_we && !w_busy && !rst;

    assign in_ready    = (r_state == S_COLLECT);
    assign busy        = w_busy;
    assign add         = r_add;
    assign match_valid = r_match_valid;
    assign match_hit   = r_match_hit;
    assign match_idx   = r_match_idx;
    assign hit_count   = r_hit_count;
    assign dbg_state   = r_state;

    // Only the first word-length characters take part in the compare.
    always_comb begin
        w_entry_data = r_key_data[r_add];
        w_chars_eq   = 1'b1;
        for (int i = 0; i < KEY_LEN; i++) begin
            if ((LW'(i) < r_count) && (w_entry_data[i*DW +: DW] != r_buf[i])) begin
                w_chars_eq = 1'b0;
            end
        end
        w_match = r_key_valid[r_add] && (r_key_len[r_add] == r_count) &&
                  !r_overflow && w_chars_eq;
    end

    // Character and length storage survives reset; only valid bits clear.
    always_ff @(posedge clk) begin
        if (w_key_wr) begin
            r_key_data[key_waddr] <= key_wdata;
            r_key_len[key_waddr]  <= key_wlen;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_valid <= '0;
        end else if (w_key_wr) begin
            r_key_valid[key_waddr] <= (key_wlen != '0) && (key_wlen <= LW'(KEY_LEN));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_COLLECT;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_add         <= '0;
            r_match_valid <= 1'b0;
            r_match_hit   <= 1'b0;
            r_match_idx   <= '0;
            r_hit_count   <= '0;
            for (int i = 0; i < KEY_LEN; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_accept) begin
                        if (r_count == LW'(KEY_LEN)) begin
                            r_overflow <= 1'b1;
                        end else begin
                            for (int i = 0; i < KEY_LEN; i++) begin
                                if (r_count == LW'(i)) begin
                                    r_buf[i] <= datain;
                                end
                            end
                            r_count <= r_count + 1'b1;
                        end
                        if (in_last) begin
                            r_state <= S_SCAN;
                            r_add   <= '0;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_match) begin
                        r_match_hit   <= 1'b1;
                        r_match_idx   <= r_add;
                        r_match_valid <= 1'b1;
                        r_state       <= S_REPORT;
                    end else if (r_add == AW'(NUM_KEYS - 1)) begin
                        r_match_hit   <= 1'b0;
                        r_match_idx   <= '0;
                        r_match_valid <= 1'b1;
                        r_state       <= S_REPORT;
                    end else begin
                        r_add <= r_add + 1'b1;
                    end
                end
                S_REPORT: begin
                    r_match_valid <= 1'b0;
                    if (r_match_hit && (r_hit_count != 16'hFFFF)) begin
                        r_hit_count <= r_hit_count + 16'd1;
                    end
                    r_count    <= '0;
                    r_overflow <= 1'b0;
                    r_add      <= '0;
                    for (int i = 0; i < KEY_LEN; i++) begin
                        r_buf[i] <= '0;
                    end
                    r_state <= S_COLLECT;
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_keyword_matcher.sv
// Directed bench for keyword_matcher: table-driven words plus hand-written
// sequences for back-pressure, duplicates, busy writes and mid-scan reset.
module tb_keyword_matcher;

    localparam int DW = 8, KEY_LEN = 8, NUM_KEYS = 16, AW = 4, LW = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [DW-1:0]         datain = '0;
    logic                  in_last = 1'b0;
    logic                  key_we = 1'b0;
    logic [AW-1:0]         key_waddr = '0;
    logic [KEY_LEN*DW-1:0] key_wdata = '0;
    logic [LW-1:0]         key_wlen = '0;
    logic [AW-1:0]         add;
    logic                  busy;
    logic                  match_valid;
    logic                  match_hit;
    logic [AW-1:0]         match_idx;
    logic [15:0]           hit_count;
    logic [1:0]            dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    keyword_matcher #(.DW(DW), .KEY_LEN(KEY_LEN), .NUM_KEYS(NUM_KEYS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .datain(datain), .in_last(in_last), .key_we(key_we),
        .key_waddr(key_waddr), .key_wdata(key_wdata), .key_wlen(key_wlen),
        .add(add), .busy(busy), .match_valid(match_valid),
        .match_hit(match_hit), .match_idx(match_idx), .hit_count(hit_count),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] w;
        int          n;
        logic        hit;
        logic [3:0]  idx;
        int          cyc;
        int          hits;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [71:0] str2w(input string s);
        logic [71:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) r[i*8 +: 8] = s[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic write_key(input int a, input string s, input int len);
        @(negedge clk);
        key_we    = 1'b1;
        key_waddr = AW'(a);
        key_wdata = str2w(s)[63:0];
        key_wlen  = LW'(len);
        @(negedge clk);
        key_we    = 1'b0;
    endtask

    task automatic send_word(input logic [71:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            datain   = w[i*8 +: 8];
            in_last  = (i == n - 1);
            @(posedge clk);
        end
    endtask

    // Called right after the edge that accepted the last character.
    task automatic wait_result(input string name, input logic exp_hit, input int exp_idx,
                               input int exp_cyc, input int exp_hits, input bit hold,
                               input bit busy_wr);
        int  cyc;
        bit  found;
        bit  add_ok;
        bit  hold_ok;
        cyc = 0; found = 0; add_ok = 1; hold_ok = 1;
        while (!found && cyc < 40) begin
            @(negedge clk);
            cyc++;
            in_last = 1'b0;
            if (hold) begin
                in_valid = 1'b1;
                datain   = "Z";
                if (in_ready !== 1'b0) hold_ok = 0;
            end else begin
                in_valid = 1'b0;
            end
            if (busy_wr && cyc == 1) begin
                key_we = 1'b1; key_waddr = 4'd5; key_wlen = '0;
            end else begin
                key_we = 1'b0;
            end
            if (match_valid === 1'b1) found = 1;
            else if (add !== AW'(cyc - 1)) add_ok = 0;
        end
        in_valid = 1'b0;
        check({name, "_found"}, 32'(found), 32'd1);
        check({name, "_latency"}, 32'(cyc), 32'(exp_cyc));
        check({name, "_hit"}, 32'(match_hit), 32'(exp_hit));
        check({name, "_idx"}, 32'(match_idx), 32'(exp_idx));
        check({name, "_add_seq"}, 32'(add_ok), 32'd1);
        if (hold) check({name, "_ready_low"}, 32'(hold_ok), 32'd1);
        @(negedge clk);
        check({name, "_pulse_one"}, 32'(match_valid), 32'd0);
        check({name, "_hit_count"}, 32'(hit_count), 32'(exp_hits));
        check({name, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_word(input string s, input logic exp_hit, input int exp_idx,
                            input int exp_cyc, input int exp_hits, input bit hold,
                            input bit busy_wr);
        send_word(str2w(s), s.len());
        wait_result(s, exp_hit, exp_idx, exp_cyc, exp_hits, hold, busy_wr);
    endtask

    initial begin
        bit mv_seen;
        vecs[0] = '{str2w("NO"),        2, 1'b1, 4'd7, 9,  1};
        vecs[1] = '{str2w("YES"),       3, 1'b1, 4'd3, 5,  2};
        vecs[2] = '{str2w("YE"),        2, 1'b0, 4'd0, 17, 2};
        vecs[3] = '{str2w("N"),         1, 1'b0, 4'd0, 17, 2};
        vecs[4] = '{str2w("NOX"),       3, 1'b0, 4'd0, 17, 2};
        vecs[5] = '{str2w("ABCDEFGH"),  8, 1'b1, 4'd0, 2,  3};
        vecs[6] = '{str2w("ABCDEFGHI"), 9, 1'b0, 4'd0, 17, 3};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_match_valid", 32'(match_valid), 32'd0);
        check("rst_match_hit", 32'(match_hit), 32'd0);
        check("rst_match_idx", 32'(match_idx), 32'd0);
        check("rst_hit_count", 32'(hit_count), 32'd0);
        check("rst_add", 32'(add), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);

        write_key(3, "YES", 3);
        write_key(7, "NO", 2);
        write_key(0, "ABCDEFGH", 8);

        for (int v = 0; v < 7; v++) begin
            send_word(vecs[v].w, vecs[v].n);
            wait_result($sformatf("vec%0d", v), vecs[v].hit, int'(vecs[v].idx),
                        vecs[v].cyc, vecs[v].hits, 1'b0, 1'b0);
        end

        // Overflowing word with in_valid held through the scan; the next
        // word must still hit, proving no stray character was taken.
        run_word("ABCDEFGHI", 1'b0, 0, 17, 3, 1'b1, 1'b0);
        run_word("NO", 1'b1, 7, 9, 4, 1'b0, 1'b0);

        // Duplicates: lowest index wins; a clear issued while busy is ignored.
        write_key(2, "GO", 2);
        write_key(5, "GO", 2);
        run_word("GO", 1'b1, 2, 4, 5, 1'b0, 1'b1);
        write_key(2, "GO", 0);
        run_word("GO", 1'b1, 5, 7, 6, 1'b0, 1'b0);
        write_key(5, "GO", 9);
        run_word("GO", 1'b0, 0, 17, 6, 1'b0, 1'b0);

        // Reset during a scan, with a simultaneous table write that must lose.
        send_word(str2w("NO"), 2);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        key_we = 1'b1; key_waddr = 4'd7; key_wdata = str2w("NO")[63:0]; key_wlen = 4'd2;
        @(negedge clk);
        rst = 1'b0;
        key_we = 1'b0;
        mv_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (match_valid === 1'b1) mv_seen = 1'b1;
            @(negedge clk);
        end
        check("midrst_no_pulse", 32'(mv_seen), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_hit", 32'(match_hit), 32'd0);
        check("midrst_idx", 32'(match_idx), 32'd0);
        check("midrst_add", 32'(add), 32'd0);
        check("midrst_hit_count", 32'(hit_count), 32'd0);
        run_word("NO", 1'b0, 0, 17, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
